spi_cmd_regs: RTL and testbench

SPI_CMD_REGS -- requirements
Module: spi_cmd_regs

---
 rtl/spi_cmd_regs.sv | 128 ++++++++++++
 tb/tb_spi_cmd_regs.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regs.sv
// SPI-written config/command registers with an acquisition control FSM.
// Tracks sticky status flags and a saturating count of accepted writes.
module spi_cmd_regs #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       iclk,
    input  logic       rstn,
    input  logic       wr_strobe,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       done,
    output logic [7:0] cfg_reg1,
    output logic [7:0] cfg_reg2,
    output logic       cmd_start,
    output logic       cmd_clear,
    output logic       busy,
    output logic [7:0] status_reg,
    output logic [7:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt, cnt_inc;
    logic       done_flag, done_flag_nxt;
    logic       timeout, timeout_nxt;
    logic       overrun, overrun_nxt;
    logic       bad_addr, bad_addr_nxt;
    logic       start_nxt, clear_nxt;
    logic       addr_ok, cmd_wr, start_req, clr_req;

    assign addr_ok   = (wr_addr >= 8'd1) && (wr_addr <= 8'd3);
    assign cmd_wr    = wr_strobe && (wr_addr == 8'd3);
    assign start_req = cmd_wr && wr_data[0];
    assign clr_req   = cmd_wr && wr_data[1];
    assign cnt_inc   = cnt + 8'd1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        done_flag_nxt = done_flag;
        timeout_nxt   = timeout;
        overrun_nxt   = overrun;
        bad_addr_nxt  = bad_addr;
        start_nxt     = 1'b0;
        clear_nxt     = 1'b0;
        if (clr_req) begin
            // CLEAR overrides everything, including a START in the same byte
            clear_nxt     = 1'b1;
            state_nxt     = IDLE;
            cnt_nxt       = 8'd0;
            done_flag_nxt = 1'b0;
            timeout_nxt   = 1'b0;
            overrun_nxt   = 1'b0;
            bad_addr_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_req) begin
                        start_nxt = 1'b1;
                        state_nxt = BUSY;
                        cnt_nxt   = 8'd0;
                    end
                end
                BUSY: begin
                    cnt_nxt = cnt_inc;
                    if (done) begin
                        state_nxt     = DONE;
                        done_flag_nxt = 1'b1;
                    end else if (cnt_inc == 8'(TIMEOUT_CYC)) begin
                        state_nxt   = IDLE;
                        timeout_nxt = 1'b1;
                        cnt_nxt     = 8'd0;
                    end
                    if (start_req) overrun_nxt = 1'b1;
                end
                DONE: begin
                    state_nxt = IDLE;
                    if (start_req) overrun_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
            if (wr_strobe && !addr_ok) bad_addr_nxt = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            done_flag <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
            bad_addr  <= 1'b0;
            cmd_start <= 1'b0;
            cmd_clear <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            done_flag <= done_flag_nxt;
            timeout   <= timeout_nxt;
            overrun   <= overrun_nxt;
            bad_addr  <= bad_addr_nxt;
            cmd_start <= start_nxt;
            cmd_clear <= clear_nxt;
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            cfg_reg1 <= 8'd0;
            cfg_reg2 <= 8'd0;
            wr_count <= 8'd0;
        end else if (wr_strobe) begin
            if (wr_addr == 8'd1) cfg_reg1 <= wr_data;
            if (wr_addr == 8'd2) cfg_reg2 <= wr_data;
            if (addr_ok && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
        end
    end

    assign busy       = (state == BUSY);
    assign status_reg = {3'b000, bad_addr, overrun, timeout, done_flag, busy};

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Directed bench for spi_cmd_regs: register writes, FSM paths, status,
// saturation and asynchronous reset.
module tb_spi_cmd_regs;

    logic       iclk = 1'b0;
    logic       rstn;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       done;
    logic [7:0] cfg_reg1;
    logic [7:0] cfg_reg2;
    logic       cmd_start;
    logic       cmd_clear;
    logic       busy;
    logic [7:0] status_reg;
    logic [7:0] wr_count;

    int total = 0;
    int bad   = 0;
    int bc;
    int wc    = 0;

    spi_cmd_regs #(.TIMEOUT_CYC(255)) dut (
        .iclk      (iclk),
        .rstn      (rstn),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .cfg_reg1  (cfg_reg1),
        .cfg_reg2  (cfg_reg2),
        .cmd_start (cmd_start),
        .cmd_clear (cmd_clear),
        .busy      (busy),
        .status_reg(status_reg),
        .wr_count  (wr_count)
    );

    always #5 iclk = ~iclk;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one strobed write; returns one step after the sampling edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_addr   = a;
        wr_data   = d;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        if (a >= 8'd1 && a <= 8'd3 && wc != 255) wc++;
    endtask

    initial begin
        rstn      = 1'b0;
        done      = 1'b0;
        wr_addr   = 8'd1;
        wr_data   = 8'h77;
        wr_strobe = 1'b1;
        tick();
        tick();
        chk("rst_cfg1", cfg_reg1, 8'h00);
        chk("rst_stat", status_reg, 8'h00);
        chk("rst_cnt", wr_count, 8'h00);
        chk("rst_busy", busy, 0);
        wr_strobe = 1'b0;
        rstn      = 1'b1;
        tick();

        wr(8'd1, 8'hA5);
        chk("cfg1", cfg_reg1, 8'hA5);
        wr(8'd2, 8'h3C);
        chk("cfg2", cfg_reg2, 8'h3C);
        chk("cfg1_keep", cfg_reg1, 8'hA5);
        chk("cnt2", wr_count, 8'd2);
        chk("stat0", status_reg, 8'h00);

        // start, done in the 10th busy cycle
        wr(8'd3, 8'h01);
        chk("start_hi", cmd_start, 1);
        chk("stat_busy", status_reg, 8'h01);
        bc = busy ? 1 : 0;
        tick();
        chk("start_1cyc", cmd_start, 0);
        if (busy) bc++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) bc++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_len10", bc, 10);
        chk("stat_done", status_reg, 8'h02);
        tick();
        chk("done_1cyc", status_reg, 8'h02);

        wr(8'd3, 8'h02);
        chk("clr_pulse", cmd_clear, 1);
        chk("clr_stat", status_reg, 8'h00);
        tick();
        chk("clr_1cyc", cmd_clear, 0);

        // timeout with done held low
        wr(8'd3, 8'h01);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 300 && busy; i++) begin
            tick();
            if (busy) bc++;
        end
        chk("to_len255", bc, 255);
        chk("to_stat", status_reg, 8'h04);

        // done on the very cycle the timeout would fire
        wr(8'd3, 8'h02);
        wr(8'd3, 8'h01);
        for (int i = 0; i < 254; i++) tick();
        chk("edge_busy", busy, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_wins", status_reg, 8'h02);

        // overrun then clear+start
        wr(8'd3, 8'h02);
        wr(8'd3, 8'h01);
        tick();
        wr(8'd3, 8'h01);
        chk("ovr_nostart", cmd_start, 0);
        chk("ovr_stat", status_reg, 8'h09);
        tick();
        wr(8'd3, 8'h03);
        chk("cs_clear", cmd_clear, 1);
        chk("cs_nostart", cmd_start, 0);
        chk("cs_busy", busy, 0);
        chk("cs_stat", status_reg, 8'h00);
        chk("cs_cfg1", cfg_reg1, 8'hA5);
        chk("cs_cnt", wr_count, wc);

        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        chk("idle_done", status_reg, 8'h00);

        // bad addresses
        wr(8'd0, 8'h11);
        wr(8'd200, 8'h22);
        chk("bad_cfg1", cfg_reg1, 8'hA5);
        chk("bad_cfg2", cfg_reg2, 8'h3C);
        chk("bad_cnt", wr_count, wc);
        chk("bad_stat", status_reg, 8'h10);

        for (int i = 0; i < 300; i++) wr(8'd1, 8'(i));
        chk("sat_cnt", wr_count, 8'hFF);
        chk("sat_model", wc, 255);
        chk("sat_cfg1", cfg_reg1, 8'(299));

        // async reset while busy
        wr(8'd1, 8'hFF);
        wr(8'd3, 8'h01);
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_cfg1", cfg_reg1, 8'h00);
        chk("ar_cfg2", cfg_reg2, 8'h00);
        chk("ar_busy", busy, 0);
        chk("ar_stat", status_reg, 8'h00);
        chk("ar_cnt", wr_count, 8'h00);
        chk("ar_start", cmd_start, 0);
        chk("ar_clear", cmd_clear, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_clear", cmd_clear, 0);
        chk("post_busy", busy, 0);
        tick();
        chk("post_clear2", cmd_clear, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
